// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the TotalALU front-end sequencer.
//   - funct codes understood by TotalALU (single-cycle ops, MULTU, MFHI, MFLO)
//   - SIG_IDLE: the harmless Signal value presented whenever no op is in flight
//   - state encoding for the sequencer FSM
//   - is_supported_funct(): true for every funct a request may carry
// No ports (package).
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  // ADD code doubles as the idle Signal: it has no side effect on HI/LO.
  localparam logic [5:0] SIG_IDLE = F_ADD;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_MUL_WAIT = 3'd2,
    S_MFHI     = 3'd3,
    S_MFLO     = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  function automatic logic is_supported_funct(input logic [5:0] f);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MULTU: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: loadable down-counter timing the MULTU hold period.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset (count -> 0)
//   load   in  load count with MUL_CYCLES-1 (has priority over dec)
//   dec    in  decrement by one; holds at zero
//   zero   out count is zero
module alu_seq_timer #(
  parameter int MUL_CYCLES = 32,
  parameter int W          = $clog2(MUL_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [W-1:0] LOAD_VAL = W'(MUL_CYCLES - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: front-end controller for a single TotalALU instance.
// Accepts one op at a time (req_valid/req_ready), drives alu_signal/alu_a/alu_b,
// holds MULTU for MUL_CYCLES cycles, then reads HI via MFHI and LO via MFLO, and
// returns the result on a valid/ready response channel.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_funct/req_a/req_b      op code and operands
//   resp_valid/resp_ready      response handshake
//   resp_lo/resp_hi/resp_err   result words, unsupported-funct flag
//   alu_rst                    active-high reset to TotalALU
//   alu_signal/alu_a/alu_b     TotalALU Signal/dataA/dataB
//   alu_out                    TotalALU Output
//   stat_ops/stat_busy         response count / non-idle cycle count
// Build option: define ALU_SEQ_STATS_EN to enable the stat_* counters; otherwise
// they are tied to zero and no counter flops exist.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_lo,
  output logic [31:0] resp_hi,
  output logic        resp_err,
  output logic        alu_rst,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_busy
);

  state_t      state_reg, state_next;
  logic [5:0]  funct_reg;
  logic [31:0] a_reg, b_reg;
  logic [31:0] resp_lo_reg, resp_hi_reg;
  logic        resp_err_reg;
  logic        alu_rst_reg;
  logic        timer_zero;
  logic        accept;
  logic        resp_done;

  assign accept    = req_valid && req_ready;
  assign resp_done = resp_valid && resp_ready;

  alu_seq_timer #(.MUL_CYCLES(MUL_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (accept && (req_funct == F_MULTU)),
    .dec   (state_reg == S_MUL_WAIT),
    .zero  (timer_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (req_funct == F_MULTU)              state_next = S_MUL_WAIT;
          else if (is_supported_funct(req_funct)) state_next = S_EXEC;
          else                                    state_next = S_RESP;
        end
      end
      S_EXEC:     state_next = S_RESP;
      S_MUL_WAIT: if (timer_zero) state_next = S_MFHI;
      S_MFHI:     state_next = S_MFLO;
      S_MFLO:     state_next = S_RESP;
      S_RESP:     if (resp_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output logic: operands are only presented while an op is in flight, so the
  // ALU never sees a stray MULTU from idle or response states.
  always_comb begin
    req_ready  = (state_reg == S_IDLE) && reset;
    resp_valid = (state_reg == S_RESP);
    alu_signal = SIG_IDLE;
    alu_a      = '0;
    alu_b      = '0;
    case (state_reg)
      S_EXEC:     begin alu_signal = funct_reg; alu_a = a_reg; alu_b = b_reg; end
      S_MUL_WAIT: begin alu_signal = F_MULTU;   alu_a = a_reg; alu_b = b_reg; end
      S_MFHI:     begin alu_signal = F_MFHI;    alu_a = a_reg; alu_b = b_reg; end
      S_MFLO:     begin alu_signal = F_MFLO;    alu_a = a_reg; alu_b = b_reg; end
      default:    ;
    endcase
  end

  assign resp_lo  = resp_lo_reg;
  assign resp_hi  = resp_hi_reg;
  assign resp_err = resp_err_reg;
  assign alu_rst  = alu_rst_reg;

  // Request capture and result collection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct_reg    <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      resp_lo_reg  <= '0;
      resp_hi_reg  <= '0;
      resp_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            funct_reg    <= req_funct;
            a_reg        <= req_a;
            b_reg        <= req_b;
            resp_lo_reg  <= '0;
            resp_hi_reg  <= '0;
            resp_err_reg <= !is_supported_funct(req_funct);
          end
        end
        S_EXEC: begin
          resp_lo_reg <= alu_out;
          resp_hi_reg <= '0;
        end
        S_MFHI:  resp_hi_reg <= alu_out;
        S_MFLO:  resp_lo_reg <= alu_out;
        default: ;
      endcase
    end
  end

  // ALU reset is held through the first clock after our own reset releases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alu_rst_reg <= 1'b1;
    else        alu_rst_reg <= 1'b0;
  end

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops_reg, stat_busy_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ops_reg  <= '0;
      stat_busy_reg <= '0;
    end else begin
      if (resp_done)            stat_ops_reg  <= stat_ops_reg + 32'd1;
      if (state_reg != S_IDLE)  stat_busy_reg <= stat_busy_reg + 32'd1;
    end
  end

  assign stat_ops  = stat_ops_reg;
  assign stat_busy = stat_busy_reg;
`else
  logic unused_stats;
  assign unused_stats = resp_done;
  assign stat_ops     = '0;
  assign stat_busy    = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural TotalALU: single-cycle ops are
// combinational on Signal, MULTU loads HI/LO each cycle it is held, MFHI/MFLO
// read them back.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_lo, resp_hi;
  logic        resp_err, alu_rst;
  logic [5:0]  alu_signal;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [31:0] stat_ops, stat_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;
  int lat;
  logic [5:0] sig_log[$];

  always #5 clk = ~clk;

  alu_sequencer #(.MUL_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_lo(resp_lo), .resp_hi(resp_hi), .resp_err(resp_err),
    .alu_rst(alu_rst), .alu_signal(alu_signal), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .stat_ops(stat_ops), .stat_busy(stat_busy)
  );

  // Behavioural TotalALU
  logic [31:0] hi_q, lo_q;
  always_ff @(posedge clk) begin
    if (alu_rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (alu_signal == 6'd25) begin
      {hi_q, lo_q} <= {32'd0, alu_a} * {32'd0, alu_b};
    end
  end

  always_comb begin
    alu_out = '0;
    case (alu_signal)
      6'd36: alu_out = alu_a & alu_b;
      6'd37: alu_out = alu_a | alu_b;
      6'd32: alu_out = alu_a + alu_b;
      6'd34: alu_out = alu_a - alu_b;
      6'd42: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'd0:  alu_out = alu_a << alu_b[4:0];
      6'd16: alu_out = hi_q;
      6'd18: alu_out = lo_q;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE. Returns cycles from the accept cycle to the
  // first cycle with resp_valid; logs alu_signal for every cycle after accept.
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      output int l);
    sig_log.delete();
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    l = 1;
    sig_log.push_back(alu_signal);
    while (!resp_valid && l < 200) begin
      @(negedge clk);
      l++;
      sig_log.push_back(alu_signal);
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_resp++;
  endtask

  initial begin
    int n25;
    int bad;
    reset = 1'b0; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready",  {63'd0, req_ready},  64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_lo",    {32'd0, resp_lo},    64'd0);
    check("rst_alu_rst",    {63'd0, alu_rst},    64'd1);
    check("rst_alu_signal", {58'd0, alu_signal}, 64'd32);
    check("rst_alu_a",      {32'd0, alu_a},      64'd0);
    check("rst_stat_ops",   {32'd0, stat_ops},   64'd0);
    reset = 1'b1;
    #1 check("alu_rst_after_release", {63'd0, alu_rst}, 64'd1);
    @(negedge clk);
    check("alu_rst_cleared", {63'd0, alu_rst}, 64'd0);

    // ADD 5+7
    send(6'd32, 32'd5, 32'd7, lat);
    $display("ADD 5+7: lat=%0d lo=%0h hi=%0h err=%0b", lat, resp_lo, resp_hi, resp_err);
    check("add_latency", 64'(lat), 64'd2);
    check("add_lo",  {32'd0, resp_lo}, 64'd12);
    check("add_hi",  {32'd0, resp_hi}, 64'd0);
    check("add_err", {63'd0, resp_err}, 64'd0);
    take_resp();

    // SUB then SLT back-to-back
    send(6'd34, 32'd3, 32'd5, lat);
    $display("SUB 3-5: lat=%0d lo=%0h", lat, resp_lo);
    check("sub_latency", 64'(lat), 64'd2);
    check("sub_lo", {32'd0, resp_lo}, 64'hFFFF_FFFE);
    check("sub_req_ready_busy", {63'd0, req_ready}, 64'd0);
    take_resp();
    send(6'd42, 32'd3, 32'd5, lat);
    $display("SLT 3<5: lat=%0d lo=%0h", lat, resp_lo);
    check("slt_lo", {32'd0, resp_lo}, 64'd1);
    take_resp();

    // MULTU 65536*65536
    send(6'd25, 32'd65536, 32'd65536, lat);
    $display("MULTU 0x10000*0x10000: lat=%0d hi=%0h lo=%0h", lat, resp_hi, resp_lo);
    check("mul_latency", 64'(lat), 64'd35);
    check("mul_hi", {32'd0, resp_hi}, 64'd1);
    check("mul_lo", {32'd0, resp_lo}, 64'd0);
    n25 = 0;
    for (int i = 0; i < sig_log.size(); i++) if (sig_log[i] == 6'd25) n25++;
    check("mul_sig25_count", 64'(n25), 64'd32);
    check("mul_log_size", 64'(sig_log.size()), 64'd35);
    if (sig_log.size() >= 34) begin
      check("mul_sig_first", {58'd0, sig_log[0]},  64'd25);
      check("mul_sig_mfhi",  {58'd0, sig_log[32]}, 64'd16);
      check("mul_sig_mflo",  {58'd0, sig_log[33]}, 64'd18);
    end
    take_resp();

    // OR with response back-pressure for 5 cycles
    send(6'd37, 32'hF0, 32'h0F, lat);
    $display("OR 0xF0|0x0F: lat=%0d lo=%0h", lat, resp_lo);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("or_hold_valid", {63'd0, resp_valid}, 64'd1);
      check("or_hold_lo",    {32'd0, resp_lo},    64'hFF);
      check("or_hold_ready", {63'd0, req_ready},  64'd0);
    end
    take_resp();

    // Unsupported funct
    send(6'd7, 32'd9, 32'd9, lat);
    $display("funct 7: lat=%0d err=%0b lo=%0h hi=%0h", lat, resp_err, resp_lo, resp_hi);
    check("bad_latency", 64'(lat), 64'd1);
    check("bad_err", {63'd0, resp_err}, 64'd1);
    check("bad_lo",  {32'd0, resp_lo},  64'd0);
    check("bad_hi",  {32'd0, resp_hi},  64'd0);
    bad = 0;
    for (int i = 0; i < sig_log.size(); i++) if (sig_log[i] != 6'd32) bad++;
    check("bad_no_alu_op", 64'(bad), 64'd0);
    take_resp();
`ifdef ALU_SEQ_STATS_EN
    check("stat_ops_before_reset", {32'd0, stat_ops}, 64'(n_resp));
`else
    check("stat_ops_tied",  {32'd0, stat_ops},  64'd0);
    check("stat_busy_tied", {32'd0, stat_busy}, 64'd0);
`endif

    // Reset during MULTU
    req_valid = 1'b1; req_funct = 6'd25; req_a = 32'd3; req_b = 32'd4;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    n_resp = 0;
    #1;
    $display("reset mid-MULTU: resp_valid=%0b alu_rst=%0b sig=%0d", resp_valid, alu_rst, alu_signal);
    check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_req_ready",  {63'd0, req_ready},  64'd0);
    check("midrst_alu_rst",    {63'd0, alu_rst},    64'd1);
    check("midrst_alu_signal", {58'd0, alu_signal}, 64'd32);
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_alu_rst_hold", {63'd0, alu_rst}, 64'd1);
    @(negedge clk);
    check("midrst_alu_rst_clear", {63'd0, alu_rst},    64'd0);
    check("midrst_no_resp",       {63'd0, resp_valid}, 64'd0);

    send(6'd32, 32'd1, 32'd1, lat);
    $display("ADD 1+1 after reset: lat=%0d lo=%0h", lat, resp_lo);
    check("post_add_latency", 64'(lat), 64'd2);
    check("post_add_lo", {32'd0, resp_lo}, 64'd2);
    take_resp();
`ifdef ALU_SEQ_STATS_EN
    check("stat_ops_final", {32'd0, stat_ops}, 64'(n_resp));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
